// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared state encoding and direction codes for the up/down counter sequencer
package cnt_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DWELL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/up_dn_step.sv
// rtl/up_dn_step.sv - wrapping up/down register stepped by one count per enabled edge
module up_dn_step
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  // Value after one step; WIDTH-bit arithmetic gives the modulo-2**WIDTH wrap.
  always_comb begin
    nxt = (dir == DIR_DN) ? q - WIDTH'(1) : q + WIDTH'(1);
  end

  // Counter register, only moves when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/updn_cnt_sequencer.sv
// rtl/updn_cnt_sequencer.sv - command-driven sequencer stepping a wrapping counter to a target
module updn_cnt_sequencer
  import cnt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DWELL_CYC = 2,
  parameter int DW        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             abort,
  output logic [WIDTH-1:0] cntr,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // Dwell counter counts down from DWELL_CYC-1 to 0, so DWELL lasts DWELL_CYC cycles.
  localparam logic [DW-1:0] DWELL_LOAD = (DWELL_CYC > 0) ? DW'(DWELL_CYC - 1) : '0;
  // Where to go once the counter sits on the target: skip DWELL entirely when no dwell.
  localparam logic [1:0] ST_AT_TGT = (DWELL_CYC == 0) ? ST_DONE : ST_DWELL;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic             dir_q;
  logic [WIDTH-1:0] cntr_nxt;
  logic [DW-1:0]    dwell_cnt;
  logic             step_en;
  logic             active;

  up_dn_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk (clk),
    .rst (rst),
    .en  (step_en),
    .dir (dir_q),
    .q   (cntr),
    .nxt (cntr_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort wins over reaching the target on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_target != cntr) ? ST_RUN : ST_AT_TGT;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (cntr_nxt == tgt_q) begin
          state_nxt = ST_AT_TGT;
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (dwell_cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; the counter freezes on an aborting edge.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    active    = (state == ST_RUN) || (state == ST_DWELL);
    busy      = active;
    step_en   = (state == ST_RUN) && !abort;
  end

  // Latch target and direction when a command is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= '0;
      dir_q <= DIR_UP;
    end else if (cmd_valid && cmd_ready) begin
      tgt_q <= cmd_target;
      dir_q <= cmd_dir;
    end
  end

  // Dwell counter: reloaded outside DWELL, counts down while dwelling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= DWELL_LOAD;
    end else if (state != ST_DWELL) begin
      dwell_cnt <= DWELL_LOAD;
    end else if (dwell_cnt != '0) begin
      dwell_cnt <= dwell_cnt - DW'(1);
    end
  end

  // Registered completion and cancellation pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= (state_nxt == ST_DONE);
      aborted <= abort && active;
    end
  end

endmodule

// File: tb/tb_updn_cnt_sequencer.sv
// tb/tb_updn_cnt_sequencer.sv - self-checking bench for updn_cnt_sequencer
module tb_updn_cnt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic       cmd_dir;
  logic       abort;
  logic [3:0] cntr;
  logic       busy;
  logic       done;
  logic       aborted;

  int tests = 0;
  int fails = 0;
  int model_cntr = 0;

  typedef struct {
    int tgt;
    int dir;
    int abort_after;
    int hold;
    int h_tgt;
    int h_dir;
    int exp_final;
  } vec_t;

  vec_t vecs[7];

  updn_cnt_sequencer #(
    .WIDTH(4),
    .DWELL_CYC(2),
    .DW(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .cntr       (cntr),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int nsteps(input int start, input int tgt, input int dir);
    return (dir == 0) ? ((tgt - start) & 15) : ((start - tgt) & 15);
  endfunction

  // Called positioned just after a negedge in an IDLE cycle; returns the same way.
  task automatic run_cmd(input int tgt, input int dir, input int abort_after,
                         input int hold, input int h_tgt, input int h_dir);
    int n, start, ka, steps, exp_c;
    start = model_cntr;
    n = nsteps(start, tgt, dir);
    ka = (abort_after < 0) ? -1 : abort_after + 1;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_target = tgt[3:0];
    cmd_dir    = dir[0];
    for (int k = 1; k <= n + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold != 0) begin
          cmd_target = h_tgt[3:0];
          cmd_dir    = h_dir[0];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (ka > 0 && k == ka + 1) begin
        steps = (ka - 1 < n) ? ka - 1 : n;
        exp_c = (dir == 0) ? ((start + steps) & 15) : ((start - steps) & 15);
        chk("abort_cntr", cntr, exp_c);
        chk("abort_pulse", aborted, 1);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        abort = 1'b0;
        model_cntr = exp_c;
        return;
      end
      steps = (k - 1 < n) ? k - 1 : n;
      exp_c = (dir == 0) ? ((start + steps) & 15) : ((start - steps) & 15);
      chk("cntr", cntr, exp_c);
      chk("busy", busy, int'(k <= n + 2));
      chk("done", done, int'(k == n + 3));
      chk("cmd_ready", cmd_ready, int'(k >= n + 4));
      chk("aborted", aborted, 0);
      if (k == ka) abort = 1'b1;
    end
    model_cntr = tgt;
  endtask

  initial begin
    vecs[0] = '{5,  0, -1, 0, 0, 0, 5};
    vecs[1] = '{14, 1, -1, 0, 0, 0, 14};
    vecs[2] = '{1,  0, -1, 0, 0, 0, 1};
    vecs[3] = '{7,  0, -1, 0, 0, 0, 7};
    vecs[4] = '{7,  0, -1, 1, 0, 1, 7};
    vecs[5] = '{0,  1, -1, 0, 0, 0, 0};
    vecs[6] = '{9,  0, 3,  0, 0, 0, 3};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_target = '0;
    cmd_dir = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cntr", cntr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_ready", cmd_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].tgt, vecs[i].dir, vecs[i].abort_after,
              vecs[i].hold, vecs[i].h_tgt, vecs[i].h_dir);
      chk("vec_final", cntr, vecs[i].exp_final);
    end

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_pulse", aborted, 0);
    chk("idle_abort_cntr", cntr, model_cntr);
    chk("idle_abort_ready", cmd_ready, 1);
    abort = 1'b0;
    @(negedge clk);

    // Randomised commands against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      int t, d, ab, n;
      t = int'($urandom_range(0, 15));
      d = int'($urandom_range(0, 1));
      n = nsteps(model_cntr, t, d);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n + 1)) : -1;
      run_cmd(t, d, ab, 0, 0, 0);
      if (($urandom_range(0, 1)) == 1) @(negedge clk);
    end

    // Asynchronous reset in the middle of a run.
    run_cmd(0, 0, -1, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd_target = 4'd9;
    cmd_dir = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_cntr", cntr, 6);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cntr", cntr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_aborted", aborted, 0);
    end
    model_cntr = 0;
    run_cmd(3, 1, -1, 0, 0, 0);
    chk("post_rst_final", cntr, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
